// File: rtl/tc_pkg.sv
// tc_pkg: shared constants for the TC_* state elements
// default data width and common reset value
package tc_pkg;

  localparam int unsigned TC_DATA_WIDTH  = 1;
  localparam logic [63:0] TC_RESET_VALUE = 64'd0;

endpackage

// File: rtl/tc_register.sv
// tc_register: single-cell storage register
// save captures in on clk; load gates the stored word onto out
module tc_register
  import tc_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = TC_DATA_WIDTH,
  parameter logic [63:0] RESET_VALUE = TC_RESET_VALUE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 save,
  input  logic [BIT_WIDTH-1:0] in,
  output logic [BIT_WIDTH-1:0] out
);

  localparam logic [BIT_WIDTH-1:0] RST_V =
    BIT_WIDTH'(RESET_VALUE);

  logic [BIT_WIDTH-1:0] value;

  // stored word: reset beats save, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RST_V;
    end else if (save) begin
      value <= in;
    end
  end

  // disabled output drives zero so registers can OR onto a bus
  assign out = load ? value : '0;

endmodule

// File: tb/tb_tc_register.sv
// tb_tc_register: directed vectors, queued expectations
// a monitor pops and compares each expected output
module tb_tc_register;

  typedef struct {
    int          sel;
    logic [7:0]  exp;
    string       name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic       save;
  logic       d1;
  logic [7:0] d8;
  logic       out0;
  logic       out1;
  logic [7:0] out8;

  exp_t q[$];
  int   pushed;
  int   popped;
  int   errors;
  int   checks;
  bit   done;

  tc_register #(
    .BIT_WIDTH   (1),
    .RESET_VALUE (64'd0)
  ) u_r0 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .save (save),
    .in   (d1),
    .out  (out0)
  );

  tc_register #(
    .BIT_WIDTH   (1),
    .RESET_VALUE (64'd1)
  ) u_r1 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .save (save),
    .in   (d1),
    .out  (out1)
  );

  tc_register #(
    .BIT_WIDTH   (8),
    .RESET_VALUE (64'd0)
  ) u_r8 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .save (save),
    .in   (d8),
    .out  (out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input int sel,
                            input logic [7:0] e,
                            input string n);
    exp_t x;
    x.sel  = sel;
    x.exp  = e;
    x.name = n;
    q.push_back(x);
    pushed = pushed + 1;
    #0;
  endtask

  // monitor: compare current DUT output with next expectation
  initial begin
    exp_t       x;
    logic [7:0] act;
    forever begin
      wait (pushed > popped);
      x = q.pop_front();
      popped = popped + 1;
      case (x.sel)
        0:       act = {7'd0, out0};
        1:       act = {7'd0, out1};
        default: act = out8;
      endcase
      checks = checks + 1;
      if (act !== x.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %h expected %h",
                 x.name, act, x.exp);
      end
    end
  end

  initial begin
    pushed = 0;
    popped = 0;
    errors = 0;
    checks = 0;
    done   = 1'b0;
    rst  = 1'b1;
    load = 1'b1;
    save = 1'b0;
    d1   = 1'b0;
    d8   = 8'h00;

    // 1: reset with load high
    @(posedge clk); #1;
    expect_out(0, 8'h00, "rst_r0_first");
    expect_out(1, 8'h01, "rst_r1_first");
    expect_out(2, 8'h00, "rst_r8_first");
    repeat (4) @(posedge clk);
    #1;
    expect_out(0, 8'h00, "rst_r0_hold");
    expect_out(1, 8'h01, "rst_r1_hold");

    // 2: save without load, then load
    @(negedge clk);
    rst  = 1'b0;
    d1   = 1'b1;
    d8   = 8'hA5;
    save = 1'b1;
    load = 1'b0;
    #1;
    expect_out(0, 8'h00, "save_noload_r0");
    expect_out(2, 8'h00, "save_noload_r8");
    @(posedge clk); #1;
    expect_out(0, 8'h00, "saved_noload_r0");
    @(negedge clk);
    save = 1'b0;
    load = 1'b1;
    #1;
    expect_out(0, 8'h01, "load_r0");
    expect_out(1, 8'h01, "load_r1");
    expect_out(2, 8'hA5, "load_r8_a5");

    // 3: hold while in toggles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d1 = ~d1;
      d8 = ~d8;
      #1;
      expect_out(0, 8'h01, "hold_r0");
    end
    expect_out(2, 8'hA5, "hold_r8");
    load = 1'b0;
    #1;
    expect_out(0, 8'h00, "unload_r0");
    expect_out(2, 8'h00, "unload_r8");

    // 4: simultaneous save and load, no bypass
    @(negedge clk);
    d1   = 1'b0;
    d8   = 8'h00;
    save = 1'b1;
    @(negedge clk);
    d1   = 1'b1;
    d8   = 8'h3C;
    load = 1'b1;
    #1;
    expect_out(0, 8'h00, "sim_pre_r0");
    expect_out(2, 8'h00, "sim_pre_r8");
    @(posedge clk); #1;
    expect_out(0, 8'h01, "sim_post_r0");
    expect_out(2, 8'h3C, "sim_post_r8");

    // 5: reset beats save
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_out(0, 8'h01, "rst_pre_r0");
    expect_out(2, 8'h3C, "rst_pre_r8");
    @(posedge clk); #1;
    expect_out(0, 8'h00, "rst_prio_r0");
    expect_out(1, 8'h01, "rst_prio_r1");
    expect_out(2, 8'h00, "rst_prio_r8");
    @(negedge clk);
    rst = 1'b0;
    d1  = 1'b1;
    @(posedge clk); #1;
    expect_out(0, 8'h01, "after_rst_r0");
    expect_out(2, 8'h3C, "after_rst_r8");

    // 6: width checks
    @(negedge clk);
    load = 1'b0;
    d8   = 8'hFF;
    #1;
    expect_out(2, 8'h00, "w_unload_r8");
    @(posedge clk); #1;
    expect_out(2, 8'h00, "w_saved_r8");
    @(negedge clk);
    save = 1'b0;
    load = 1'b1;
    d8   = 8'h81;
    #1;
    expect_out(2, 8'hFF, "w_load_ff");
    @(posedge clk); #1;
    expect_out(2, 8'hFF, "w_hold_ff");

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

  // end of run: drain scoreboard within a bound
  initial begin
    int budget;
    wait (done);
    budget = 100;
    while (popped < pushed && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    if (popped != pushed) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d popped expected %0d",
               popped, pushed);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  // watchdog so the run always terminates
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
